// File: rtl/parallel_in_serial_out_piso_tx.sv
// rtl/parallel_in_serial_out_piso_tx.sv - PISO transmitter: valid/ready word load, one bit per enabled clock
// Drives serial data plus a per-bit strobe; a load on the last bit chains words with no idle gap.
module parallel_in_serial_out_piso_tx #(
  parameter int DATA_WIDTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Load_Valid_In,
  output logic                  Load_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Shift_Data_Signal_Out,
  output logic                  Busy_Out,
  output logic                  Done_Out
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_bit, load_ready, load_accept;

  assign last_bit    = (state_q == SHIFT) && (cnt_q == LAST_BIT);
  assign load_ready  = Enable_In && ((state_q == IDLE) || last_bit);
  assign load_accept = load_ready && Load_Valid_In;

  // Shift toward whichever end feeds the serial line, zero filling behind.
  assign shifted = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[DATA_WIDTH-1:1]};

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (Enable_In) begin
      case (state_q)
        IDLE: begin
          if (load_accept) begin
            state_d = SHIFT;
            shreg_d = Parallel_Data_In;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CNT_ONE;
          if (last_bit) begin
            cnt_d = '0;
            if (load_accept) begin
              shreg_d = Parallel_Data_In;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // While paused the register holds, so the line keeps showing the pending bit.
  assign Serial_Data_Out       = (state_q == SHIFT) &&
                                 (MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0]);
  assign Shift_Data_Signal_Out = (state_q == SHIFT) && Enable_In;
  assign Busy_Out              = (state_q == SHIFT);
  assign Done_Out              = last_bit && Enable_In;
  assign Load_Ready_Out        = load_ready;

endmodule
